tenkey_debounce: RTL and testbench
==================================

# tenkey_debounce

Front-end stage for the electronic lock. It synchronises and debounces the ten raw keypad contacts, then validates each press: exactly one key must be down. For every valid press it produces a one-cycle, one-hot `tenkey` strobe that the lock's key encoder consumes. Multi-key presses are rejected with an error strobe, and no further output is produced until every key is released.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive identical synchronised samples required before a new contact state is accepted; legal range 2..65535.
- `CNT_W`, default 16: width of the debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

- `clk`  in  1: single system clock; all state updates on its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `sw_raw`  in  10: raw keypad contacts, active-high, bit i = digit i; asynchronous to `clk`, may bounce.
- `tenkey`  out  10: one-hot strobe of the accepted digit; all-zero except for the single strobe cycle.
- `key_valid`  out  1: high exactly in the cycle `tenkey` is non-zero.
- `key_err`  out  1: one-cycle strobe when more than one key is accepted as down at once.

## Operation
- **Synchroniser.** Two-flop chain: `sync1 <= sw_raw`, `sync2 <= sync1`.
- **Debounce.**
  - `cand` holds the last `sync2` value; `cnt` counts consecutive edges on which `sync2 == cand`.
  - If `sync2 != cand`: `cand <= sync2`, `cnt <= 1`.
  - Else, if `cnt < DEBOUNCE_CYCLES`: `cnt` increments.
  - When `cnt == DEBOUNCE_CYCLES` and `stable != cand`: `stable <= cand`.
  - `cnt` saturates at `DEBOUNCE_CYCLES`; it never wraps.
- **FSM**, advanced from `stable`:
  - IDLE: `stable == 0`. On exactly one bit set → PRESSED. On ≥2 bits set → MULTI.
  - PRESSED, one cycle: `tenkey <= stable`, `key_valid <= 1`; then → HELD.
  - HELD: outputs zero. If `stable == 0` → IDLE. If extra bits appear (≥2 set) → MULTI. A change to a different single bit is ignored; a release must come first.
  - MULTI: emits `key_err` for one cycle on entry, outputs zero, stays until `stable == 0` → IDLE.
- **Output rules.**
  - Exactly one strobe per debounced press; holding a key never repeats the strobe.
  - `tenkey` is always either all-zero or one-hot, never anything else.
  - `key_valid` and `key_err` are never high in the same cycle.
- **Reset.**
  - All registers clear asynchronously: `sync1`, `sync2`, `cand`, `stable`, `tenkey` = 0; `cnt` = 0; `key_valid` = 0; `key_err` = 0; FSM = IDLE.
  - A key already held when reset deasserts is accepted as a fresh press once debounced.

## Timing
- Outputs are registered; no combinational path from `sw_raw` to any output.
- Press latency, for `sw_raw` changing before edge k and then holding steady:
  - `sync2` updates at edge k+1.
  - `stable` updates at edge k+DEBOUNCE_CYCLES+1.
  - FSM enters PRESSED at edge k+DEBOUNCE_CYCLES+2.
  - `tenkey`/`key_valid` are high for the one cycle following that edge.
  - With the default of 4, the strobe follows edge k+6.
- Release latency: the same debounce path; HELD → IDLE at edge k+DEBOUNCE_CYCLES+2.
- Bounce shorter than DEBOUNCE_CYCLES cycles never changes `stable`.
- Reset asserted mid-strobe clears outputs immediately (asynchronously). Reset deassertion is treated as synchronous to `clk` by the system.

## Test plan
- Reset, then `sw_raw = 10'b0000001000` held 20 cycles → exactly one cycle with `tenkey = 10'b0000001000` and `key_valid = 1`, following edge 6 after the change; all other cycles zero.
- Digit 3 toggled every 2 cycles for 12 cycles, then released → no `key_valid` and no `key_err` strobe.
- Press digit 3, release, press digit 7 (each held 10 cycles, release 10 cycles) → two strobes, `10'b0000001000` then `10'b0010000000`.
- Press digits 2 and 5 together (`10'b0000100100`) for 10 cycles → one `key_err` pulse, `tenkey` stays 0; after release, digit 1 gives a normal strobe.
- Hold digit 4, then add digit 6 while held → one `key_valid` for digit 4, then one `key_err`, and no further strobes until full release.
- Assert `reset` during the `key_valid` cycle → `tenkey`, `key_valid` drop to 0 immediately. After deassertion with digit 9 still held, one strobe `10'b1000000000` appears DEBOUNCE_CYCLES+2 edges later.

Source files
------------

// File: rtl/tenkey_debounce.sv
// Keypad front end: two-flop synchroniser, per-vector debounce and a press
// validator that emits one one-hot strobe per single-key press.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | no key accepted as down; waiting for a debounced press
// S_PRESSED | strobe cycle for a valid single-key press
// S_HELD    | key still down after its strobe; waiting for release
// S_MULTI   | more than one key seen; silent until every key is released
module tenkey_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] sw_raw,
    output logic [9:0] tenkey,
    output logic       key_valid,
    output logic       key_err
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESSED,
        S_HELD,
        S_MULTI
    } state_t;

    logic [9:0]       sync1;
    logic [9:0]       sync2;
    logic [9:0]       cand;
    logic [9:0]       stable;
    logic [CNT_W-1:0] cnt;
    state_t           state;

    logic stable_zero;
    logic stable_multi;
    logic stable_one;

    assign stable_zero  = (stable == 10'd0);
    assign stable_multi = |(stable & (stable - 10'd1));
    assign stable_one   = !stable_zero && !stable_multi;

    // stable takes cand on the same edge that the run of matching samples
    // reaches DEBOUNCE_CYCLES, so acceptance costs no extra cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1  <= 10'd0;
            sync2  <= 10'd0;
            cand   <= 10'd0;
            stable <= 10'd0;
            cnt    <= '0;
        end else begin
            sync1 <= sw_raw;
            sync2 <= sync1;
            if (sync2 != cand) begin
                cand <= sync2;
                cnt  <= CNT_ONE;
            end else begin
                if (cnt < CNT_MAX) begin
                    cnt <= cnt + CNT_ONE;
                end
                if ((cnt >= CNT_LAST) && (stable != cand)) begin
                    stable <= cand;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            tenkey    <= 10'd0;
            key_valid <= 1'b0;
            key_err   <= 1'b0;
        end else begin
            tenkey    <= 10'd0;
            key_valid <= 1'b0;
            key_err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (stable_one) begin
                        tenkey    <= stable;
                        key_valid <= 1'b1;
                        state     <= S_PRESSED;
                    end else if (stable_multi) begin
                        key_err <= 1'b1;
                        state   <= S_MULTI;
                    end
                end
                S_PRESSED: begin
                    state <= S_HELD;
                end
                S_HELD: begin
                    // a switch to a different single key is ignored until release
                    if (stable_zero) begin
                        state <= S_IDLE;
                    end else if (stable_multi) begin
                        key_err <= 1'b1;
                        state   <= S_MULTI;
                    end
                end
                S_MULTI: begin
                    if (stable_zero) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tenkey_debounce.sv
// Scoreboard bench for tenkey_debounce: stimulus queues expected strobes,
// a negedge monitor pops and compares them and checks output invariants.
module tb_tenkey_debounce;

    localparam int DC = 4;

    logic       clk;
    logic       reset;
    logic [9:0] sw_raw;
    logic [9:0] tenkey;
    logic       key_valid;
    logic       key_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        bit         is_err;
        logic [9:0] val;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];

    tenkey_debounce #(
        .DEBOUNCE_CYCLES(DC),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sw_raw(sw_raw),
        .tenkey(tenkey),
        .key_valid(key_valid),
        .key_err(key_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // monitor: invariants every cycle, scoreboard pop on every strobe
    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if (key_valid !== (tenkey != 10'd0)) begin
                failures++;
                $display("FAIL valid_vs_tenkey cyc=%0d key_valid=%b tenkey=%b", cyc, key_valid, tenkey);
            end
            checks++;
            if ((tenkey & (tenkey - 10'd1)) != 10'd0) begin
                failures++;
                $display("FAIL tenkey_onehot cyc=%0d tenkey=%b", cyc, tenkey);
            end
            checks++;
            if (key_valid && key_err) begin
                failures++;
                $display("FAIL valid_and_err cyc=%0d both high", cyc);
            end
            if (key_valid || key_err) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_strobe cyc=%0d tenkey=%b key_valid=%b key_err=%b",
                             cyc, tenkey, key_valid, key_err);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checks++;
                    if (key_err !== e.is_err) begin
                        failures++;
                        $display("FAIL strobe_kind cyc=%0d got key_err=%b want key_err=%b", cyc, key_err, e.is_err);
                    end
                    checks++;
                    if (tenkey !== (e.is_err ? 10'd0 : e.val)) begin
                        failures++;
                        $display("FAIL strobe_value cyc=%0d got %b want %b", cyc, tenkey, e.is_err ? 10'd0 : e.val);
                    end
                    if (e.cyc >= 0) begin
                        checks++;
                        if (cyc != e.cyc) begin
                            failures++;
                            $display("FAIL strobe_cycle got cyc=%0d want cyc=%0d", cyc, e.cyc);
                        end
                    end
                end
            end
        end
    end

    task automatic expect_ev(input bit is_err, input logic [9:0] val, input int at);
        exp_t e;
        e.is_err = is_err;
        e.val    = val;
        e.cyc    = at;
        exp_q.push_back(e);
    endtask

    // drive v at a negedge and hold for n cycles
    task automatic drive(input logic [9:0] v, input int n);
        @(negedge clk);
        sw_raw = v;
        repeat (n - 1) @(negedge clk);
    endtask

    initial begin
        int  c;
        bit  seen;
        reset  = 1'b1;
        sw_raw = 10'd0;
        repeat (2) @(negedge clk);

        checks++;
        if (tenkey !== 10'd0) begin
            failures++;
            $display("FAIL reset_tenkey got %b want 0", tenkey);
        end
        checks++;
        if (key_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_key_valid got %b want 0", key_valid);
        end
        checks++;
        if (key_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_key_err got %b want 0", key_err);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // single press of digit 3 with exact latency
        c = cyc;
        expect_ev(1'b0, 10'b0000001000, c + 1 + DC + 2);
        sw_raw = 10'b0000001000;
        repeat (19) @(negedge clk);
        drive(10'd0, 10);

        // bounce on digit 3 shorter than the debounce window
        for (int i = 0; i < 6; i++) begin
            drive((i % 2 == 0) ? 10'b0000001000 : 10'd0, 2);
        end
        drive(10'd0, 10);

        // press 3, release, press 7
        expect_ev(1'b0, 10'b0000001000, -1);
        drive(10'b0000001000, 10);
        drive(10'd0, 10);
        expect_ev(1'b0, 10'b0010000000, -1);
        drive(10'b0010000000, 10);
        drive(10'd0, 10);

        // two keys at once, then a normal press of digit 1
        expect_ev(1'b1, 10'd0, -1);
        drive(10'b0000100100, 10);
        drive(10'd0, 10);
        expect_ev(1'b0, 10'b0000000010, -1);
        drive(10'b0000000010, 10);
        drive(10'd0, 10);

        // hold 4, add 6, drop back to 6 only, then release
        expect_ev(1'b0, 10'b0000010000, -1);
        drive(10'b0000010000, 10);
        expect_ev(1'b1, 10'd0, -1);
        drive(10'b0001010000, 10);
        drive(10'b0001000000, 10);
        drive(10'd0, 10);

        // reset during the strobe cycle of digit 9
        @(negedge clk);
        c = cyc;
        expect_ev(1'b0, 10'b1000000000, c + 1 + DC + 2);
        sw_raw = 10'b1000000000;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (key_valid) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL wait_digit9 got no key_valid want key_valid within 20 cycles");
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (tenkey !== 10'd0) begin
            failures++;
            $display("FAIL async_reset_tenkey got %b want 0", tenkey);
        end
        checks++;
        if (key_valid !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_key_valid got %b want 0", key_valid);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        expect_ev(1'b0, 10'b1000000000, -1);
        repeat (15) @(negedge clk);
        drive(10'd0, 10);

        repeat (5) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_strobes got %0d outstanding want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
